npu_ctrl_seq: RTL and testbench
===============================

Name: npu_ctrl_seq

Overview:
Parametrised instruction sequencer for the TinyNPU, and the successor to the single-shot control FSM. It buffers host instruction words from the h2f bridge in an instruction FIFO and decodes each one. It then sequences XRAM load/store bursts, FU parameter fetch, and 1- or 2-operand FU execution, waiting for per-FU completion with a timeout. Status, error and retire count are reported on f2h_io.

Parameters:
FIFO_DEPTH, 8, instruction FIFO entries (power of 2, 2..128)
NUM_FU, 32, number of functional units (fun field is 5 bits; fun >= NUM_FU is illegal)
RADDR_W, 8, XRAM register address width
EXT_ADDR_W, 24, external SDRAM word address width (<= 24)
TIMEOUT, 4096, max cycles waiting for a done or ack; 0 = disabled

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
h2f_io  in  32  host instruction/control word
h2f_write  in  1  1-cycle write strobe for h2f_io
f2h_io  out  32  status {busy, err, err_code[2:0], 3'b0, fifo_level[7:0], retired[15:0]}
xfer_req  out  1  transfer request, held until xfer_ack
xfer_dir  out  1  0 = SDRAM->XRAM (LD), 1 = XRAM->SDRAM (ST)
xfer_ext_addr  out  EXT_ADDR_W  SDRAM start address
xfer_bram_addr  out  16  XRAM start address
xfer_len  out  16  word count
xfer_ack  in  1  request accepted
xfer_done  in  1  1-cycle transfer completion pulse
fun  out  5  active FU index, held from DECODE until retire
fetch_start  out  1  1-cycle FU parameter fetch start
ex_start  out  1  1-cycle FU execute start
x1_ld, x2_ld  out  1  1-cycle operand load strobes
xram_raddr  out  RADDR_W  operand read address, valid with x1_ld/x2_ld
wa  out  RADDR_W  write-back address, valid with ex_start
fu_done  in  NUM_FU  level done flag per FU

Behaviour:
- Word format: op = [31:29], fun = [28:24], payload = [23:0]. Op codes:
  - 0 NOP
  - 1 LD, 2 ST: payload = ext_addr; a second word follows, {bram_addr[31:16], len[15:0]}
  - 3 FETCH
  - 4 EX1, 5 EX2: payload = {ra1, ra2, wa}, 8 bits each
  - 6 SYNC: wait until all fu_done are high
  - 7 CTRL
- CTRL is never enqueued and acts in the cycle after the write. payload[0] clears err and leaves HALT. payload[1] flushes the FIFO. Both bits set: clear and flush together.
- Any write other than CTRL while the FIFO is full is dropped and sets err code 1 (OVF). The sequencer does not halt for OVF.
- Reset: state IDLE, FIFO empty, all strobes 0, xfer_req 0, fun/wa/xram_raddr/xfer_* 0, err 0, err_code 0, retired 0.
- States: IDLE, DECODE, WORD2, XFER_REQ, XFER_WAIT, FETCH, X1_LD, X2_LD, EX_START, WAIT_DONE, SYNC, HALT.
- IDLE: if the FIFO is non-empty, pop and go to DECODE.
- DECODE, by op:
  - NOP: retire, go to IDLE.
  - LD/ST: go to WORD2.
  - FETCH: go to FETCH.
  - EX1/EX2: go to X1_LD.
  - SYNC: go to SYNC.
  - fun >= NUM_FU on FETCH/EX: err code 2 (BADFU), go to HALT.
- WORD2: wait for non-empty, pop, latch bram_addr/len, go to XFER_REQ.
- len == 0: retire without raising xfer_req.
- XFER_REQ: xfer_req = 1 until xfer_ack; on ack go to XFER_WAIT. XFER_WAIT: on xfer_done, retire and go to IDLE.
- FETCH: fetch_start = 1 for one cycle, then WAIT_DONE.
- X1_LD: x1_ld = 1, xram_raddr = ra1. Next state is X2_LD for EX2, otherwise EX_START.
- X2_LD: x2_ld = 1, xram_raddr = ra2, then EX_START.
- EX_START: ex_start = 1, wa valid, then WAIT_DONE.
- WAIT_DONE: fu_done[fun] is first sampled the cycle after entry. When sampled high, retire and go to IDLE.
- SYNC: when &fu_done is high, retire and go to IDLE.
- Timeout: when TIMEOUT != 0, a counter runs in XFER_REQ, XFER_WAIT, WAIT_DONE, SYNC and WORD2. It resets on every state entry. Reaching TIMEOUT sets err code 3 (TMO), deasserts xfer_req, and goes to HALT.
- HALT: no pops. Exit to IDLE only by CTRL clear. The FIFO contents are kept unless flushed.
- Error reporting: err is sticky; err_code keeps the first error until clear.
- Retire: retired += 1, wraps modulo 2^16.
- busy = (state != IDLE) or FIFO non-empty.
- Latency from an EX1 write in cycle N, sequencer idle and FIFO empty:
  - FIFO non-empty in N+1; DECODE in N+2
  - x1_ld in N+3; ex_start in N+4
  - WAIT_DONE from N+5; fu_done is first sampled in N+6
- Simultaneous events:
  - A push and a pop in the same cycle while full: the pop wins first, so the push is accepted and the level is unchanged.
  - A flush in the same cycle as a pop: the FIFO is empty afterwards.
  - A flush does not abort the in-flight instruction. WORD2 then waits for a new word or times out.
- rst mid-operation: everything returns to reset values and xfer_req drops in the next cycle.

Decomposition:
- npu_pkg: op_t enum, state_t enum, err_code_t enum (NONE 0, OVF 1, BADFU 2, TMO 3), field-slice constants.
- Sub-module: npu_inst_fifo, a synchronous FIFO with push/pop/flush/level.

Test Plan:
- EX2 0xA3_01_02_03 (fun=3) written in cycle N, fu_done[3] raised at N+8 -> x1_ld at N+3 with raddr 0x01; x2_ld at N+4 with raddr 0x02; ex_start at N+5 with wa 0x03; retired=1 at N+10.
- LD 0x20_001000 then 0x0040_0010 -> xfer_req with dir 0, ext 0x001000, bram 0x0040, len 16; ack after 3 cycles; done pulse -> retired+1. Same with len=0 -> no xfer_req, retired+1.
- 9 writes back-to-back while HALTed (FIFO_DEPTH=8) -> fifo_level=8, err=1, err_code=OVF; CTRL payload 3 -> level 0, err 0, IDLE.
- FETCH fun=31 with NUM_FU=16 -> no fetch_start, err_code=BADFU, HALT; following queued NOP not retired until CTRL clear.
- TIMEOUT=16, EX1 with fu_done held low -> err_code=TMO 16 cycles after WAIT_DONE entry; SYNC with all fu_done high -> retires in 1 cycle.
- rst asserted during XFER_REQ -> xfer_req=0 and f2h_io=0 in the next cycle.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared TinyNPU sequencer types: opcodes, FSM states, error codes and instruction word layouts.
// Pure declarations; no timing or flow-control behaviour of its own.
package npu_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LD    = 3'd1,
      OP_ST    = 3'd2,
      OP_FETCH = 3'd3,
      OP_EX1   = 3'd4,
      OP_EX2   = 3'd5,
      OP_SYNC  = 3'd6,
      OP_CTRL  = 3'd7
   } op_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DECODE,
      S_WORD2,
      S_XFER_REQ,
      S_XFER_WAIT,
      S_FETCH,
      S_X1_LD,
      S_X2_LD,
      S_EX_START,
      S_WAIT_DONE,
      S_SYNC,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_OVF   = 3'd1,
      ERR_BADFU = 3'd2,
      ERR_TMO   = 3'd3
   } err_code_t;

   // First instruction word; for LD/ST the three byte fields form the ext address.
   typedef struct packed {
      op_t        op;
      logic [4:0] fun;
      logic [7:0] ra1;
      logic [7:0] ra2;
      logic [7:0] wa;
   } instr_t;

   typedef struct packed {
      logic [15:0] bram_addr;
      logic [15:0] len;
   } word2_t;

   localparam int WORD_W      = 32;
   localparam int CTRL_CLR_B  = 0;
   localparam int CTRL_FLSH_B = 1;

endpackage

// File: rtl/npu_inst_fifo.sv
// Synchronous FIFO with push/pop/flush and level; pop and flush take effect before push.
// Zero-latency read (dout is head entry); a push into a full FIFO is refused unless a pop or flush frees room.
module npu_inst_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   full,
   output logic                   accept
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   cnt;
   logic          do_pop;

   assign empty  = (cnt == '0);
   assign full   = (cnt == (AW+1)'(DEPTH));
   assign do_pop = pop && !empty;
   assign accept = push && (!full || do_pop || flush);
   assign dout   = mem[rd_ptr];
   assign level  = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         // A push in the flush cycle lands in slot 0 of the emptied FIFO.
         rd_ptr <= '0;
         wr_ptr <= AW'(accept);
         cnt    <= (AW+1)'(accept);
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(accept) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[flush ? '0 : wr_ptr] <= din;
   end

endmodule

// File: rtl/npu_ctrl_seq.sv
// TinyNPU instruction sequencer: buffers host words, decodes, drives XRAM bursts and FU fetch/execute, reports status.
// EX1 written in cycle N gives x1_ld at N+3 and ex_start at N+4; xfer_req holds until xfer_ack, FU waits bounded by TIMEOUT.
module npu_ctrl_seq
   import npu_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_FU     = 32,
   parameter int RADDR_W    = 8,
   parameter int EXT_ADDR_W = 24,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           h2f_io,
   input  logic                  h2f_write,
   output logic [31:0]           f2h_io,
   output logic                  xfer_req,
   output logic                  xfer_dir,
   output logic [EXT_ADDR_W-1:0] xfer_ext_addr,
   output logic [15:0]           xfer_bram_addr,
   output logic [15:0]           xfer_len,
   input  logic                  xfer_ack,
   input  logic                  xfer_done,
   output logic [4:0]            fun,
   output logic                  fetch_start,
   output logic                  ex_start,
   output logic                  x1_ld,
   output logic                  x2_ld,
   output logic [RADDR_W-1:0]    xram_raddr,
   output logic [RADDR_W-1:0]    wa,
   input  logic [NUM_FU-1:0]     fu_done
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          state, state_nxt;
   instr_t          instr;
   instr_t          wr_word;
   word2_t          w2_head;
   logic [15:0]     bram_r, len_r;
   logic            first;
   logic [TMO_W-1:0] tmo_cnt;
   logic            tmo_hit, timed;
   logic            err;
   err_code_t       err_code, err_new;
   logic            set_err, retire;
   logic [15:0]     retired;
   logic            ctrl_clr, ctrl_flush;
   logic            is_ctrl, push, pop;
   logic [31:0]     fifo_dout;
   logic [LVL_W-1:0] fifo_level;
   logic            fifo_empty, fifo_full, fifo_accept;
   logic            ovf, fun_bad, busy;
   logic [31:0]     done_ext;

   assign wr_word = instr_t'(h2f_io);
   assign is_ctrl = h2f_write && (wr_word.op == OP_CTRL);
   assign push    = h2f_write && !is_ctrl;
   assign ovf     = push && !fifo_accept;

   npu_inst_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (WORD_W)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .flush  (ctrl_flush),
      .din    (h2f_io),
      .dout   (fifo_dout),
      .level  (fifo_level),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .accept (fifo_accept)
   );

   assign w2_head  = word2_t'(fifo_dout);
   assign done_ext = 32'(fu_done);
   assign fun_bad  = ({27'b0, instr.fun} >= 32'(NUM_FU));
   assign timed    = (state == S_WORD2) || (state == S_XFER_REQ) || (state == S_XFER_WAIT) ||
                     (state == S_WAIT_DONE) || (state == S_SYNC);
   assign tmo_hit  = (TIMEOUT != 0) && timed && (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign busy     = (state != S_IDLE) || !fifo_empty;

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      retire      = 1'b0;
      set_err     = 1'b0;
      err_new     = ERR_NONE;
      xfer_req    = 1'b0;
      fetch_start = 1'b0;
      ex_start    = 1'b0;
      x1_ld       = 1'b0;
      x2_ld       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            case (instr.op)
               OP_NOP: begin
                  retire    = 1'b1;
                  state_nxt = S_IDLE;
               end
               OP_LD, OP_ST: state_nxt = S_WORD2;
               OP_FETCH, OP_EX1, OP_EX2: begin
                  if (fun_bad) begin
                     set_err   = 1'b1;
                     err_new   = ERR_BADFU;
                     state_nxt = S_HALT;
                  end else begin
                     state_nxt = (instr.op == OP_FETCH) ? S_FETCH : S_X1_LD;
                  end
               end
               OP_SYNC: state_nxt = S_SYNC;
               default: state_nxt = S_IDLE;
            endcase
         end
         S_WORD2: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               // A zero-length burst completes without touching the transfer engine.
               if (w2_head.len == '0) begin
                  retire    = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_XFER_REQ;
               end
            end else if (tmo_hit) begin
               set_err   = 1'b1;
               err_new   = ERR_TMO;
               state_nxt = S_HALT;
            end
         end
         S_XFER_REQ: begin
            xfer_req = 1'b1;
            if (xfer_ack) begin
               state_nxt = S_XFER_WAIT;
            end else if (tmo_hit) begin
               set_err   = 1'b1;
               err_new   = ERR_TMO;
               state_nxt = S_HALT;
            end
         end
         S_XFER_WAIT: begin
            if (xfer_done) begin
               retire    = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo_hit) begin
               set_err   = 1'b1;
               err_new   = ERR_TMO;
               state_nxt = S_HALT;
            end
         end
         S_FETCH: begin
            fetch_start = 1'b1;
            state_nxt   = S_WAIT_DONE;
         end
         S_X1_LD: begin
            x1_ld     = 1'b1;
            state_nxt = (instr.op == OP_EX2) ? S_X2_LD : S_EX_START;
         end
         S_X2_LD: begin
            x2_ld     = 1'b1;
            state_nxt = S_EX_START;
         end
         S_EX_START: begin
            ex_start  = 1'b1;
            state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // The FU has not seen the start strobe yet in the entry cycle, so its done flag is stale.
            if (!first && done_ext[instr.fun]) begin
               retire    = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo_hit) begin
               set_err   = 1'b1;
               err_new   = ERR_TMO;
               state_nxt = S_HALT;
            end
         end
         S_SYNC: begin
            if (&fu_done) begin
               retire    = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo_hit) begin
               set_err   = 1'b1;
               err_new   = ERR_TMO;
               state_nxt = S_HALT;
            end
         end
         S_HALT: begin
            if (ctrl_clr) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         first   <= 1'b1;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         first   <= (state_nxt != state);
         if (state_nxt != state) tmo_cnt <= '0;
         else if (timed)         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr  <= '0;
         bram_r <= '0;
         len_r  <= '0;
      end else if (pop) begin
         if (state == S_IDLE) begin
            instr <= instr_t'(fifo_dout);
         end else begin
            bram_r <= w2_head.bram_addr;
            len_r  <= w2_head.len;
         end
      end
   end

   // CTRL words act one cycle after the write, never through the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_clr   <= 1'b0;
         ctrl_flush <= 1'b0;
      end else begin
         ctrl_clr   <= is_ctrl && h2f_io[CTRL_CLR_B];
         ctrl_flush <= is_ctrl && h2f_io[CTRL_FLSH_B];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
         retired  <= '0;
         f2h_io   <= '0;
      end else begin
         if (ctrl_clr) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
         end
         if (set_err && (!err || ctrl_clr)) begin
            err      <= 1'b1;
            err_code <= err_new;
         end else if (ovf && (!err || ctrl_clr)) begin
            err      <= 1'b1;
            err_code <= ERR_OVF;
         end
         if (retire) retired <= retired + 1'b1;
         f2h_io <= {busy, err, err_code, 3'b000, 8'(fifo_level), retired};
      end
   end

   assign fun            = instr.fun;
   assign wa             = RADDR_W'(instr.wa);
   assign xram_raddr     = (state == S_X2_LD) ? RADDR_W'(instr.ra2) : RADDR_W'(instr.ra1);
   assign xfer_dir       = (instr.op == OP_ST);
   assign xfer_ext_addr  = EXT_ADDR_W'({instr.ra1, instr.ra2, instr.wa});
   assign xfer_bram_addr = bram_r;
   assign xfer_len       = len_r;

endmodule

// File: tb/tb_npu_ctrl_seq.sv
// Directed bench for npu_ctrl_seq (FIFO_DEPTH=8, NUM_FU=16, TIMEOUT=16); cycle-exact hand-computed expectations.
module tb_npu_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] h2f_io;
   logic        h2f_write;
   logic [31:0] f2h_io;
   logic        xfer_req, xfer_dir;
   logic [23:0] xfer_ext_addr;
   logic [15:0] xfer_bram_addr, xfer_len;
   logic        xfer_ack, xfer_done;
   logic [4:0]  fun;
   logic        fetch_start, ex_start, x1_ld, x2_ld;
   logic [7:0]  xram_raddr, wa;
   logic [15:0] fu_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   npu_ctrl_seq #(
      .FIFO_DEPTH (8),
      .NUM_FU     (16),
      .RADDR_W    (8),
      .EXT_ADDR_W (24),
      .TIMEOUT    (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .h2f_io         (h2f_io),
      .h2f_write      (h2f_write),
      .f2h_io         (f2h_io),
      .xfer_req       (xfer_req),
      .xfer_dir       (xfer_dir),
      .xfer_ext_addr  (xfer_ext_addr),
      .xfer_bram_addr (xfer_bram_addr),
      .xfer_len       (xfer_len),
      .xfer_ack       (xfer_ack),
      .xfer_done      (xfer_done),
      .fun            (fun),
      .fetch_start    (fetch_start),
      .ex_start       (ex_start),
      .x1_ld          (x1_ld),
      .x2_ld          (x2_ld),
      .xram_raddr     (xram_raddr),
      .wa             (wa),
      .fu_done        (fu_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Write in the current cycle; returns at the negedge of the following cycle.
   task automatic wr(input logic [31:0] w);
      h2f_io    = w;
      h2f_write = 1'b1;
      tick(1);
      h2f_write = 1'b0;
   endtask

   initial begin
      rst = 1'b1; h2f_io = '0; h2f_write = 1'b0;
      xfer_ack = 1'b0; xfer_done = 1'b0; fu_done = '0;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("reset_f2h", f2h_io, 32'h0);
      chk("reset_strobes", {27'b0, xfer_req, fetch_start, ex_start, x1_ld, x2_ld}, 32'h0);
      chk("reset_fun_wa", {11'b0, fun, xram_raddr, wa}, 32'h0);

      // EX2 fun=3: x1_ld N+3, x2_ld N+4, ex_start N+5, done at N+8, retired visible N+10
      wr(32'hA301_0203);
      tick(2);
      chk("ex2_x1_ld", {23'b0, x1_ld, xram_raddr}, 32'h0000_0101);
      tick(1);
      chk("ex2_x2_ld", {23'b0, x2_ld, xram_raddr}, 32'h0000_0102);
      tick(1);
      chk("ex2_ex_start", {18'b0, ex_start, fun, wa}, 32'h0000_2303);
      tick(3);
      fu_done = 16'h0008;
      tick(1);
      fu_done = '0;
      chk("ex2_busy_n9", f2h_io, 32'h8000_0000);
      tick(1);
      chk("ex2_retired_n10", f2h_io, 32'h0000_0001);

      // FETCH fun=1 with done already high: entry cycle of WAIT_DONE must not retire
      fu_done = 16'h0002;
      wr(32'h6100_0000);
      tick(2);
      chk("fetch_start_on", {31'b0, fetch_start}, 32'h1);
      tick(1);
      chk("fetch_start_off", {31'b0, fetch_start}, 32'h0);
      tick(2);
      chk("fetch_wait_first", f2h_io, 32'h8000_0001);
      tick(1);
      chk("fetch_retired", f2h_io, 32'h0000_0002);
      fu_done = '0;

      // LD ext 0x001000, bram 0x0040, len 16; ack after 3 cycles
      wr(32'h2000_1000);
      wr(32'h0040_0010);
      tick(2);
      chk("ld_req", {31'b0, xfer_req}, 32'h1);
      chk("ld_dir_ext", {7'b0, xfer_dir, xfer_ext_addr}, 32'h0000_1000);
      chk("ld_bram_len", {xfer_bram_addr, xfer_len}, 32'h0040_0010);
      tick(3);
      chk("ld_req_held", {31'b0, xfer_req}, 32'h1);
      xfer_ack = 1'b1;
      tick(1);
      xfer_ack = 1'b0;
      chk("ld_req_dropped", {31'b0, xfer_req}, 32'h0);
      tick(2);
      xfer_done = 1'b1;
      tick(1);
      xfer_done = 1'b0;
      chk("ld_busy", f2h_io, 32'h8000_0002);
      tick(1);
      chk("ld_retired", f2h_io, 32'h0000_0003);

      // LD with len 0: never requests, still retires
      wr(32'h2000_0005);
      wr(32'h0100_0000);
      for (int i = 0; i < 4; i++) begin
         chk("ld0_no_req", {31'b0, xfer_req}, 32'h0);
         tick(1);
      end
      chk("ld0_retired", f2h_io, 32'h0000_0004);

      // FETCH fun=31 >= NUM_FU: BADFU, HALT; queued NOP waits for clear
      wr(32'h7F00_0000);
      wr(32'h0000_0000);
      for (int i = 0; i < 6; i++) begin
         chk("badfu_no_fetch", {31'b0, fetch_start}, 32'h0);
         tick(1);
      end
      chk("badfu_status", f2h_io, 32'hD001_0004);
      tick(4);
      chk("badfu_nop_held", f2h_io, 32'hD001_0004);
      wr(32'hE000_0001);
      tick(5);
      chk("clear_nop_retired", f2h_io, 32'h0000_0005);

      // SYNC blocks, then 9 NOPs: FIFO fills to 8, last one overflows; later TMO keeps OVF code
      wr(32'hC000_0000);
      for (int i = 0; i < 9; i++) wr(32'h0000_0000);
      tick(1);
      chk("ovf_status", f2h_io, 32'hC808_0005);
      tick(11);
      chk("ovf_sticky_after_tmo", f2h_io, 32'hC808_0005);
      wr(32'h0000_0000);
      wr(32'hE000_0003);
      tick(2);
      chk("ctrl_clear_flush", f2h_io, 32'h0000_0005);

      // EX1 fun=2 with done low: TMO 16 cycles after WAIT_DONE entry (U+5)
      wr(32'h8201_0203);
      tick(20);
      chk("tmo_not_yet", f2h_io, 32'h8000_0005);
      tick(1);
      chk("tmo_status", f2h_io, 32'hD800_0005);
      wr(32'hE000_0001);
      tick(2);
      chk("tmo_cleared", f2h_io, 32'h0000_0005);

      // SYNC with all done high retires in its first cycle
      fu_done = 16'hFFFF;
      wr(32'hC000_0000);
      tick(3);
      chk("sync_busy", f2h_io, 32'h8000_0005);
      tick(1);
      chk("sync_retired", f2h_io, 32'h0000_0006);
      fu_done = '0;

      // rst during XFER_REQ
      wr(32'h2000_0100);
      wr(32'h0000_0010);
      tick(2);
      chk("rst_pre_req", {31'b0, xfer_req}, 32'h1);
      rst = 1'b1;
      tick(1);
      chk("rst_req_low", {31'b0, xfer_req}, 32'h0);
      chk("rst_f2h_zero", f2h_io, 32'h0);
      chk("rst_xfer_regs", {xfer_bram_addr, xfer_len}, 32'h0);
      rst = 1'b0;
      tick(2);
      chk("post_rst_idle", f2h_io, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
